// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard/flow sequencer.
// Holds the sequencer state encoding and the register-file geometry.
package pipeline_sequencer_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      BR_WAIT = 1'b1
   } seq_state_t;

   localparam int REG_NUM_WIDTH = 5;
   localparam int REG_COUNT     = 1 << REG_NUM_WIDTH;
   localparam int SB_CNT_WIDTH  = 2;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_sequencer_scoreboard.sv
// Per-register pending-write counters with two combinational busy lookups.
// Latency: busy reflects the counters as of the last edge; no backpressure.
module pipeline_sequencer_scoreboard
   import pipeline_sequencer_pkg::*;
#(
   parameter int REG_NUM_WIDTH = 5,
   parameter int SB_CNT_WIDTH  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc_i,
   input  logic [REG_NUM_WIDTH-1:0] inc_num_i,
   input  logic                     dec_i,
   input  logic [REG_NUM_WIDTH-1:0] dec_num_i,
   input  logic [REG_NUM_WIDTH-1:0] rd_a_num_i,
   input  logic [REG_NUM_WIDTH-1:0] rd_b_num_i,
   output logic                     rd_a_busy_o,
   output logic                     rd_b_busy_o
);

   localparam int NREG = 1 << REG_NUM_WIDTH;
   localparam logic [SB_CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [SB_CNT_WIDTH-1:0] CNT_ONE = SB_CNT_WIDTH'(1);

   logic [SB_CNT_WIDTH-1:0] cnt_q [NREG];
   logic [SB_CNT_WIDTH-1:0] cnt_d [NREG];

   logic inc_hit;
   logic dec_hit;
   logic same_reg;

   assign inc_hit  = inc_i && (inc_num_i != '0);
   assign dec_hit  = dec_i && (dec_num_i != '0);
   assign same_reg = inc_hit && dec_hit && (inc_num_i == dec_num_i);

   // Register 0 never tracks writes; a coincident inc/dec on one register cancels.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
      end
      if (inc_hit && !same_reg) begin
         cnt_d[inc_num_i] = cnt_q[inc_num_i] + CNT_ONE;
      end
      if (dec_hit && !same_reg) begin
         cnt_d[dec_num_i] = cnt_q[dec_num_i] - CNT_ONE;
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   assign rd_a_busy_o = (cnt_q[rd_a_num_i] != '0);
   assign rd_b_busy_o = (cnt_q[rd_b_num_i] != '0);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      (inc_hit && !same_reg) |-> (cnt_q[inc_num_i] != CNT_MAX))
      else $fatal(1, "scoreboard counter overflow");

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
      dec_hit |-> (cnt_q[dec_num_i] != '0))
      else $fatal(1, "scoreboard counter underflow");

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard and flow controller: RAW stall on pending writes, branch-shadow hold.
// Outputs are combinational from state, scoreboard and ID/WB inputs (zero latency).
module pipeline_sequencer #(
   parameter int REG_NUM_WIDTH = pipeline_sequencer_pkg::REG_NUM_WIDTH,
   parameter int SB_CNT_WIDTH  = pipeline_sequencer_pkg::SB_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     idValid,
   input  logic [REG_NUM_WIDTH-1:0] idRs,
   input  logic [REG_NUM_WIDTH-1:0] idRt,
   input  logic                     idUseRs,
   input  logic                     idUseRt,
   input  logic [REG_NUM_WIDTH-1:0] idDst,
   input  logic                     idRfWrEnable,
   input  logic                     idIsBranch,
   input  logic                     memBrResolve,
   input  logic                     wbRfWrEnable,
   input  logic [REG_NUM_WIDTH-1:0] wbWrNum,
   output logic                     pcHold,
   output logic                     ifidHold,
   output logic                     ifidFlush,
   output logic                     idexBubble,
   output logic                     idIssue
);

   import pipeline_sequencer_pkg::*;

   seq_state_t state_q;
   seq_state_t state_d;

   logic rs_busy;
   logic rt_busy;
   logic raw_stall;

   pipeline_sequencer_scoreboard #(
      .REG_NUM_WIDTH (REG_NUM_WIDTH),
      .SB_CNT_WIDTH  (SB_CNT_WIDTH)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (idIssue && idRfWrEnable),
      .inc_num_i   (idDst),
      .dec_i       (wbRfWrEnable),
      .dec_num_i   (wbWrNum),
      .rd_a_num_i  (idRs),
      .rd_b_num_i  (idRt),
      .rd_a_busy_o (rs_busy),
      .rd_b_busy_o (rt_busy)
   );

   assign raw_stall = idValid && ((idUseRs && rs_busy) || (idUseRt && rt_busy));

   always_comb begin
      pcHold     = 1'b0;
      ifidHold   = 1'b0;
      ifidFlush  = 1'b0;
      idexBubble = 1'b0;
      idIssue    = 1'b0;
      state_d    = state_q;
      if (!rst) begin
         pcHold     = 1'b1;
         ifidFlush  = 1'b1;
         idexBubble = 1'b1;
         state_d    = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (raw_stall) begin
                  pcHold     = 1'b1;
                  ifidHold   = 1'b1;
                  idexBubble = 1'b1;
               end else if (idValid && idIsBranch) begin
                  // Branch goes to EX; the wrong-path fetch behind it is discarded.
                  idIssue   = 1'b1;
                  pcHold    = 1'b1;
                  ifidFlush = 1'b1;
                  state_d   = BR_WAIT;
               end else begin
                  idIssue = idValid;
               end
            end
            BR_WAIT: begin
               ifidFlush  = 1'b1;
               idexBubble = 1'b1;
               pcHold     = !memBrResolve;
               if (memBrResolve) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed-vector bench: the driver queues hand-computed outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_sequencer;

   typedef struct packed {
      logic       rst;
      logic       idValid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       useRs;
      logic       useRt;
      logic [4:0] dst;
      logic       wr;
      logic       br;
      logic       res;
      logic       wbw;
      logic [4:0] wbn;
   } stim_t;

   typedef struct {
      logic [4:0] v;
      string      nm;
   } exp_t;

   // {pcHold, ifidHold, ifidFlush, idexBubble, idIssue}
   localparam logic [4:0] E_RST = 5'b10110;
   localparam logic [4:0] E_ISS = 5'b00001;
   localparam logic [4:0] E_IDL = 5'b00000;
   localparam logic [4:0] E_STL = 5'b11010;
   localparam logic [4:0] E_BRI = 5'b10101;
   localparam logic [4:0] E_BRW = 5'b10110;
   localparam logic [4:0] E_BRR = 5'b00110;

   logic       clk;
   logic       rst;
   logic       idValid;
   logic [4:0] idRs;
   logic [4:0] idRt;
   logic       idUseRs;
   logic       idUseRt;
   logic [4:0] idDst;
   logic       idRfWrEnable;
   logic       idIsBranch;
   logic       memBrResolve;
   logic       wbRfWrEnable;
   logic [4:0] wbWrNum;
   logic       pcHold;
   logic       ifidHold;
   logic       ifidFlush;
   logic       idexBubble;
   logic       idIssue;

   stim_t s;
   exp_t  exp_q [$];
   exp_t  cur;
   int    checks = 0;
   int    passes = 0;

   pipeline_sequencer #(
      .REG_NUM_WIDTH (5),
      .SB_CNT_WIDTH  (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .idValid      (idValid),
      .idRs         (idRs),
      .idRt         (idRt),
      .idUseRs      (idUseRs),
      .idUseRt      (idUseRt),
      .idDst        (idDst),
      .idRfWrEnable (idRfWrEnable),
      .idIsBranch   (idIsBranch),
      .memBrResolve (memBrResolve),
      .wbRfWrEnable (wbRfWrEnable),
      .wbWrNum      (wbWrNum),
      .pcHold       (pcHold),
      .ifidHold     (ifidHold),
      .ifidFlush    (ifidFlush),
      .idexBubble   (idexBubble),
      .idIssue      (idIssue)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply();
      rst          = s.rst;
      idValid      = s.idValid;
      idRs         = s.rs;
      idRt         = s.rt;
      idUseRs      = s.useRs;
      idUseRt      = s.useRt;
      idDst        = s.dst;
      idRfWrEnable = s.wr;
      idIsBranch   = s.br;
      memBrResolve = s.res;
      wbRfWrEnable = s.wbw;
      wbWrNum      = s.wbn;
   endtask

   task automatic clr();
      s     = '0;
      s.rst = 1'b1;
   endtask

   task automatic cyc(input logic [4:0] e, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      apply();
      x.v  = e;
      x.nm = nm;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         checks++;
         if ({pcHold, ifidHold, ifidFlush, idexBubble, idIssue} == cur.v) begin
            passes++;
         end else begin
            $display("FAIL %s: got {pcHold,ifidHold,ifidFlush,idexBubble,idIssue}=%b required %b",
                     cur.nm, {pcHold, ifidHold, ifidFlush, idexBubble, idIssue}, cur.v);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      s.rst = 1'b0;
      apply();

      // Reset with a live instruction in ID
      clr(); s.rst = 1'b0; s.idValid = 1; s.rs = 5; s.useRs = 1;
      cyc(E_RST, "rst_cycle0");
      cyc(E_RST, "rst_cycle1");
      clr(); s.idValid = 1; s.rs = 5; s.useRs = 1; s.rt = 7; s.useRt = 1;
      cyc(E_ISS, "post_rst_no_stall");
      clr();
      cyc(E_IDL, "idle_run");

      // RAW distance 1 on r5
      clr(); s.idValid = 1; s.dst = 5; s.wr = 1;
      cyc(E_ISS, "raw_writer_r5");
      clr(); s.idValid = 1; s.rs = 5; s.useRs = 1;
      cyc(E_STL, "raw_stall1");
      cyc(E_STL, "raw_stall2");
      s.wbw = 1; s.wbn = 5;
      cyc(E_STL, "raw_stall3_wb");
      s.wbw = 0;
      cyc(E_ISS, "raw_issue");

      // rt path and unused-source gating on r12
      clr(); s.idValid = 1; s.dst = 12; s.wr = 1;
      cyc(E_ISS, "writer_r12");
      clr(); s.idValid = 1; s.rs = 12; s.useRs = 0; s.rt = 3; s.useRt = 1;
      cyc(E_ISS, "unused_rs_no_stall");
      clr(); s.idValid = 1; s.rt = 12; s.useRt = 1;
      cyc(E_STL, "rt_stall1");
      s.wbw = 1; s.wbn = 12;
      cyc(E_STL, "rt_stall2_wb");
      s.wbw = 0;
      cyc(E_ISS, "rt_issue");

      // Coincident increment and decrement on r7
      clr(); s.idValid = 1; s.dst = 7; s.wr = 1;
      cyc(E_ISS, "writer_r7_a");
      clr();
      cyc(E_IDL, "gap_r7");
      clr(); s.idValid = 1; s.dst = 7; s.wr = 1; s.wbw = 1; s.wbn = 7;
      cyc(E_ISS, "writer_r7_b_with_wb");
      clr(); s.idValid = 1; s.rs = 7; s.useRs = 1;
      cyc(E_STL, "r7_still_pending");
      s.wbw = 1; s.wbn = 7;
      cyc(E_STL, "r7_second_commit");
      s.wbw = 0;
      cyc(E_ISS, "r7_issue");

      // Register 0 never stalls
      clr(); s.idValid = 1; s.dst = 0; s.wr = 1;
      cyc(E_ISS, "writer_r0");
      clr(); s.idValid = 1; s.rs = 0; s.useRs = 1; s.rt = 0; s.useRt = 1; s.wbw = 1; s.wbn = 0;
      cyc(E_ISS, "reader_r0");

      // Branch without hazards
      clr(); s.idValid = 1; s.br = 1; s.rs = 1; s.useRs = 1;
      cyc(E_BRI, "br_issue");
      clr(); s.idValid = 1;
      cyc(E_BRW, "br_wait");
      s.res = 1;
      cyc(E_BRR, "br_resolve");
      clr(); s.idValid = 1;
      cyc(E_ISS, "br_back_to_run");

      // Branch whose source is pending must stall first
      clr(); s.idValid = 1; s.dst = 9; s.wr = 1;
      cyc(E_ISS, "writer_r9");
      clr(); s.idValid = 1; s.br = 1; s.rs = 9; s.useRs = 1;
      cyc(E_STL, "brh_stall1");
      cyc(E_STL, "brh_stall2");
      s.wbw = 1; s.wbn = 9;
      cyc(E_STL, "brh_stall3_wb");
      s.wbw = 0;
      cyc(E_BRI, "brh_issue");
      clr();
      cyc(E_BRW, "brh_wait");
      s.res = 1;
      cyc(E_BRR, "brh_resolve");
      clr();
      cyc(E_IDL, "brh_run_idle");

      // Reset while in BR_WAIT with two writes to r3 pending
      clr(); s.idValid = 1; s.dst = 3; s.wr = 1;
      cyc(E_ISS, "writer_r3_a");
      cyc(E_ISS, "writer_r3_b");
      clr(); s.idValid = 1; s.br = 1;
      cyc(E_BRI, "br2_issue");
      clr();
      cyc(E_BRW, "br2_wait");
      clr(); s.rst = 0; s.idValid = 1;
      cyc(E_RST, "rst_mid_branch");
      clr(); s.idValid = 1; s.rs = 3; s.useRs = 1;
      cyc(E_ISS, "r3_clear_after_rst");

      // Reset during a RAW stall on r4
      clr(); s.idValid = 1; s.dst = 4; s.wr = 1;
      cyc(E_ISS, "writer_r4");
      clr(); s.idValid = 1; s.rt = 4; s.useRt = 1;
      cyc(E_STL, "r4_stall");
      s.rst = 0;
      cyc(E_RST, "rst_mid_stall");
      s.rst = 1;
      cyc(E_ISS, "r4_clear_after_rst");
      clr();
      cyc(E_IDL, "final_idle");

      for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
         @(negedge clk);
      end
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: got %0d unchecked entries required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
